frequency_regulator: RTL and testbench
======================================

FREQUENCY_REGULATOR -- requirements
Module: frequency_regulator

Interface
REQ-001 Parameter WIDTH, default 8: width of setPeriod and of the internal counters.
REQ-002 clk  input  1: single clock; all state updates on its rising edge; bench drives it from a free-running ring-oscillator model.
REQ-003 rst  input  1: reset, asynchronous and active-low; rst=0 forces the reset state immediately, independent of clk.
REQ-004 setPeriod  input  WIDTH: requested output period P, in clk cycles; unsigned.
REQ-005 clk_div  output  1: divided clock; registered, glitch-free, driven directly from a flop.

Function
REQ-006 Internal state: period register per_q (WIDTH), phase counter cnt (WIDTH), clk_div flop.
REQ-007 Period boundary is true when per_q < 2, or when cnt == per_q-1.
REQ-008 At a boundary edge: cnt <= 0, per_q <= setPeriod; otherwise cnt <= cnt+1.
REQ-009 setPeriod is sampled only at boundary edges; changes mid-period take effect only after the current period completes.
REQ-010 High phase H = P - floor(P/2); low phase L = floor(P/2); for P=50, H=25 and L=25; for odd P, the extra cycle is high.
REQ-011 clk_div is registered from next-state values: clk_div <= 1 iff next per_q >= 2 and next cnt < H(next per_q).
REQ-012 Result for P>=2: clk_div is high for H consecutive rising edges, then low for L, repeating with period exactly P cycles.
REQ-013 P=2: clk_div toggles every cycle; P=3: 2 cycles high, 1 cycle low; P=255: 128 high, 127 low.
REQ-014 P=0 or P=1 (divide-by-1 not realisable from a flop): clk_div held 0, cnt held 0, setPeriod re-sampled every edge.
REQ-015 Leaving P<2 for P>=2: the first edge sampling the new value starts a period, with cnt=0 and clk_div=1.
REQ-016 No combinational path from setPeriod to clk_div.
REQ-017 Counter arithmetic is unsigned WIDTH-bit; cnt never exceeds per_q-1, so no wrap-around can occur.

Reset
REQ-018 While rst=0: cnt=0, per_q=0, clk_div=0, asynchronously.
REQ-019 First rising edge with rst=1 is a boundary (per_q=0): it loads setPeriod and, if P>=2, drives clk_div=1 with cnt=0.
REQ-020 Reset asserted mid-period aborts the period immediately; no partial high pulse survives reset.
REQ-021 Reset deassertion is expected synchronised to clk by the system; the block adds no synchroniser.

Structure
REQ-022 Shared package holds the WIDTH default (8) and the half-period function H(P)=P-(P>>1), for reuse by the bench scoreboard.
REQ-023 Single flat module; no sub-module is required.
REQ-024 The ring-oscillator clock source is a simulation-only model and is not part of this block's RTL.
REQ-025 Ring-oscillator model parameters: NO_STAGES (odd, default 3), INV_DELAY_ps (default 66); enable input en; output clk.
REQ-026 Ring-oscillator model behaviour: clk held static while en=0; when oscillating, period = 2*NO_STAGES*INV_DELAY_ps (396 ps at the defaults).

Verification
REQ-027 Bench setup: clock from the ring-oscillator model, enabled at 200 ps; rst=0 from 50 ps to 200 ps, then held 1.
REQ-028 Scenario: setPeriod=50 (0x32), reset released -> first edge clk_div=1; 25 edges high, 25 low; steady period 50 cycles (19.8 ns).
REQ-029 Scenario: setPeriod=3 -> repeating 2-cycle-high, 1-cycle-low pattern; setPeriod=2 -> toggle on every edge.
REQ-030 Scenario: setPeriod changed 50->10 at cycle 7 of a period -> current 50-cycle period completes unchanged, then 5 high / 5 low.
REQ-031 Scenario: setPeriod=0 and then 1 -> clk_div constant 0; then setPeriod=4 -> next edge clk_div=1, then 2 high / 2 low.
REQ-032 Scenario: rst pulsed low mid high-phase -> clk_div=0 within the same timestep; after release, restarts per REQ-019.

Source files
------------

// File: rtl/frequency_regulator_pkg.sv
// Shared constants and helpers for the frequency regulator.
// The half-period rule lives here so every user agrees on it.
package frequency_regulator_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  // High phase takes the extra cycle of an odd period.
  function automatic logic [31:0] half_period(
    input logic [31:0] p
  );
    return p - (p >> 1);
  endfunction

endpackage

// File: rtl/frequency_regulator.sv
// Divides clk by a runtime period setPeriod, giving a flop-driven
// clk_div with the longer half high; period 0/1 parks the output low.
module frequency_regulator
  import frequency_regulator_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] setPeriod,
  output logic             clk_div
);

  logic [WIDTH-1:0] per_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] hi_d;
  logic             boundary;
  logic             div_d;

  always_comb begin
    boundary = (per_q < WIDTH'(2))
            || (cnt == per_q - WIDTH'(1));
    per_d    = boundary ? setPeriod : per_q;
    cnt_d    = boundary ? '0 : cnt + WIDTH'(1);
    hi_d     = WIDTH'(half_period(32'(per_d)));
    // Output follows next state so it lines up with cnt.
    div_d    = (per_d >= WIDTH'(2)) && (cnt_d < hi_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_q   <= '0;
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      per_q   <= per_d;
      cnt     <= cnt_d;
      clk_div <= div_d;
    end
  end

endmodule

// File: tb/tb_frequency_regulator.sv
// Directed bench for frequency_regulator, clocked by a
// ring-oscillator model; expectations go through a scoreboard queue.
module tb_frequency_regulator;
  import frequency_regulator_pkg::*;

  localparam int NO_STAGES    = 3;
  localparam int INV_DELAY_ps = 66;
  localparam int HALF = NO_STAGES * INV_DELAY_ps;
  localparam int W    = 8;

  logic         en  = 1'b0;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] setPeriod = '0;
  logic         clk_div;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  longint rise_t[$];

  frequency_regulator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .setPeriod (setPeriod),
    .clk_div   (clk_div)
  );

  // Ring oscillator: static while disabled.
  always begin
    if (!en) @(posedge en);
    #HALF clk = ~clk;
  end

  always @(posedge clk_div) rise_t.push_back($time);

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_t(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive setPeriod before n rising edges, expecting val after each.
  task automatic run(input int sp, input bit val, input int n);
    for (int i = 0; i < n; i++) begin
      setPeriod = W'(sp);
      exp_q.push_back(val);
      @(negedge clk);
    end
  endtask

  // Monitor: compare each rising edge against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #20;
      if (exp_q.size() > 0) chk("clk_div", clk_div, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    setPeriod = 8'h32;
    #50 rst = 1'b0;
    #100 chk("reset_state", clk_div, 1'b0);
    #50;
    rst = 1'b1;
    en  = 1'b1;

    // P=50: two full periods from reset release.
    run(50, 1'b1, 25);
    run(50, 1'b0, 25);
    run(50, 1'b1, 25);
    run(50, 1'b0, 25);
    if (rise_t.size() >= 2)
      chk_t("period_50_ps", rise_t[1] - rise_t[0], 50 * 2 * HALF);
    else
      chk_t("period_50_rises", rise_t.size(), 2);
    chk_t("half_50", half_period(50), 25);
    chk_t("half_255", half_period(255), 128);

    // 50 -> 10 at cycle 7: the old period finishes first.
    run(50, 1'b1, 7);
    run(10, 1'b1, 18);
    run(10, 1'b0, 25);
    run(10, 1'b1, 5);
    run(10, 1'b0, 5);
    run(10, 1'b1, 5);
    run(10, 1'b0, 5);

    // P=3 then P=2.
    for (int i = 0; i < 3; i++) begin
      run(3, 1'b1, 2);
      run(3, 1'b0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      run(2, 1'b1, 1);
      run(2, 1'b0, 1);
    end

    // P=0 and P=1 park low; P=4 restarts high.
    run(0, 1'b0, 4);
    run(1, 1'b0, 4);
    for (int i = 0; i < 2; i++) begin
      run(4, 1'b1, 2);
      run(4, 1'b0, 2);
    end

    // Widest period.
    run(255, 1'b1, 128);
    run(255, 1'b0, 127);

    // Reset mid high phase, between clock edges.
    run(50, 1'b1, 10);
    #10 rst = 1'b0;
    #1 chk("reset_async", clk_div, 1'b0);
    #10 rst = 1'b1;
    run(50, 1'b1, 25);
    run(50, 1'b0, 3);

    chk_t("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
